imem_boot_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of `Single_Cycle_Top`. It receives a program image over a valid/ready byte interface and assembles little-endian 32-bit words. It writes those words into the instruction memory write port and holds the processor in reset until the image is fully loaded. It then releases the processor's active-low `rst`.

---
 rtl/imem_boot_pkg.sv | 21 ++
 rtl/boot_word_assembler.sv | 40 ++++
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 tb/tb_imem_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
`default_nettype none
// imem_boot_pkg: shared state encoding and image-format constants for the IMEM boot loader.
// The CSUM state exists only when IMEM_BOOT_CHECKSUM_EN is defined.
package imem_boot_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_LOAD  = 3'd2,
`ifdef IMEM_BOOT_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/boot_word_assembler.sv
`default_nettype none
// boot_word_assembler: packs accepted bytes into little-endian 32-bit words,
// flagging the word combinationally on the byte that completes it.
module boot_word_assembler
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned          LANE_W    = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (take_i) begin
      lane_q  <= lane_q + LANE_W'(1);
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  // Only the first three bytes are held; the fourth is merged on the fly.
  assign word_valid_o = take_i && (lane_q == LAST_LANE);
  assign word_o       = {byte_i, shift_q};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// imem_boot_loader: loads a length-prefixed byte image into IMEM, then releases the CPU reset.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W     = HDR_BYTES * 8;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_e      ST_TAIL   = ST_CSUM;
`else
  localparam state_e      ST_TAIL   = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q;
  logic [ADDR_W:0]   wcnt_q;
  logic              in_ready_q, imem_we_q, cpu_rst_q, done_q, error_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic              accept, load_take, reload_ok, word_valid, last_word;
  logic [31:0]       word;
  logic [CNT_W-1:0]  n_hdr;
  logic [ADDR_W:0]   wcnt_inc;

  assign accept    = in_valid && in_ready_q;
  assign load_take = accept && (state_q == ST_LOAD);
  assign reload_ok = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign n_hdr     = {in_data, n_q[7:0]};
  assign wcnt_inc  = wcnt_q + 1'b1;
  assign last_word = (32'(wcnt_inc) == 32'(n_q));

  boot_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (reload_ok),
    .take_i       (load_take),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR0: if (accept) state_d = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (n_hdr == '0)                    state_d = ST_TAIL;
          else if (32'(n_hdr) > MAX_WORDS)    state_d = ST_ERROR;
          else                                state_d = ST_LOAD;
        end
      end
      ST_LOAD: if (word_valid && last_word) state_d = ST_TAIL;
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CSUM: if (accept) state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE, ST_ERROR: if (reload) state_d = ST_HDR0;
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HDR0;
      n_q          <= '0;
      wcnt_q       <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_DONE) && (state_d != ST_ERROR);
      done_q     <= (state_d == ST_DONE);
      error_q    <= (state_d == ST_ERROR);
      // Release lags DONE entry by one edge so the final write lands first.
      cpu_rst_q  <= (state_q == ST_DONE) && (state_d == ST_DONE);
      imem_we_q  <= 1'b0;

      if (accept && (state_q == ST_HDR0)) n_q[7:0]       <= in_data;
      if (accept && (state_q == ST_HDR1)) n_q[CNT_W-1:8] <= in_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (load_take) xor_q <= xor_q ^ in_data;
`endif
      if (word_valid) begin
        imem_we_q    <= 1'b1;
        imem_addr_q  <= wcnt_q[ADDR_W-1:0];
        imem_wdata_q <= word;
        wcnt_q       <= wcnt_inc;
      end
      if (reload_ok) begin
        n_q    <= '0;
        wcnt_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        xor_q  <= '0;
`endif
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// tb_imem_boot_loader: directed self-checking bench for the IMEM boot loader.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              reload = 1'b0;
  logic              in_ready, imem_we, cpu_rst, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [31:0] img[$];
  logic [7:0]  tb_xor;

  always @(negedge clk) begin
    if (rst && imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_if(input bit gap);
    if (gap) @(negedge clk);
  endtask

  // Sends header, all words in img, and (with the checksum feature) a trailing XOR byte.
  task automatic send_image(input bit gap, input bit bad_csum);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(img.size());
    tb_xor = 8'h00;
    send_byte(n[7:0]);  idle_if(gap);
    send_byte(n[15:8]); idle_if(gap);
    foreach (img[i]) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        tb_xor = tb_xor ^ w[8*k +: 8];
        idle_if(gap);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(bad_csum ? (tb_xor ^ 8'h01) : tb_xor);
`else
    if (bad_csum) @(negedge clk);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_reload();
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  int bad;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_we", imem_we, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_wdata", imem_wdata, 0);
    check_eq("rst_cpu_rst", cpu_rst, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    rst = 1'b1;

    // N=2 back-to-back, with release timing
    img = '{32'h00000013, 32'h00100093};
    send_image(1'b0, 1'b0);
    @(negedge clk);
    check_eq("t2_done_edge", done, 1);
    check_eq("t2_cpu_held", cpu_rst, 0);
`ifndef IMEM_BOOT_CHECKSUM_EN
    check_eq("t2_last_we", imem_we, 1);
    check_eq("t2_last_addr", imem_addr, 1);
`endif
    check_eq("t2_ready_off", in_ready, 0);
    @(negedge clk);
    check_eq("t2_cpu_release", cpu_rst, 1);
    check_eq("t2_we_off", imem_we, 0);
    #1;
    check_eq("t2_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check_eq("t2_a0", wa[0], 0);
      check_eq("t2_d0", wd[0], 32'h00000013);
      check_eq("t2_a1", wa[1], 1);
      check_eq("t2_d1", wd[1], 32'h00100093);
    end

    // Reload from DONE, then same image with in_valid toggling; a reload in LOAD is ignored
    pulse_reload();
    check_eq("rl_done", done, 0);
    check_eq("rl_cpu_rst", cpu_rst, 0);
    check_eq("rl_ready", in_ready, 1);
    wa.delete(); wd.delete();
    tb_xor = 8'h00;
    send_byte(8'h02); idle_if(1'b1);
    send_byte(8'h00); idle_if(1'b1);
    pulse_reload();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(img[i][8*k +: 8]);
        tb_xor = tb_xor ^ img[i][8*k +: 8];
        idle_if(1'b1);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(tb_xor);
`endif
    settle();
    check_eq("t3_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check_eq("t3_d0", wd[0], 32'h00000013);
      check_eq("t3_a1", wa[1], 1);
      check_eq("t3_d1", wd[1], 32'h00100093);
    end
    check_eq("t3_done", done, 1);
    check_eq("t3_cpu_rst", cpu_rst, 1);

    // N=0x0101 exceeds capacity
    apply_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    check_eq("t4_error", error, 1);
    check_eq("t4_ready", in_ready, 0);
    check_eq("t4_cpu_rst", cpu_rst, 0);
    in_data = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("t4_error_hold", error, 1);
    check_eq("t4_cpu_hold", cpu_rst, 0);
    check_eq("t4_done", done, 0);
    check_eq("t4_nwr", wa.size(), 0);

    // N=0 finishes straight after the header
    apply_reset();
    img.delete();
    send_image(1'b0, 1'b0);
    @(negedge clk);
    check_eq("t5_done", done, 1);
    check_eq("t5_cpu_held", cpu_rst, 0);
    @(negedge clk);
    check_eq("t5_cpu_release", cpu_rst, 1);
    check_eq("t5_nwr", wa.size(), 0);

    // N=256 fills the whole memory
    apply_reset();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back({~8'(i), 8'hC3, 8'(i), 8'h5A});
    send_image(1'b0, 1'b0);
    settle();
    check_eq("t6_nwr", wa.size(), 256);
    check_eq("t6_done", done, 1);
    check_eq("t6_error", error, 0);
    if (wa.size() == 256) begin
      check_eq("t6_a0", wa[0], 8'h00);
      check_eq("t6_d0", wd[0], 32'hFFC3005A);
      check_eq("t6_alast", wa[255], 8'hFF);
      check_eq("t6_dlast", wd[255], 32'h00C3FF5A);
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wa[i] !== 8'(i) || wd[i] !== {~8'(i), 8'hC3, 8'(i), 8'h5A}) bad++;
      check_eq("t6_all_words", bad, 0);
    end

    // Async reset mid-word abandons the partial word
    apply_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t7_rst_ready", in_ready, 1);
    check_eq("t7_rst_we", imem_we, 0);
    rst = 1'b1;
    img = '{32'h44332211};
    send_image(1'b0, 1'b0);
    settle();
    check_eq("t7_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      check_eq("t7_a0", wa[0], 0);
      check_eq("t7_d0", wd[0], 32'h44332211);
    end
    check_eq("t7_done", done, 1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum accept, reject, then recover via reload
    apply_reset();
    img = '{32'h08040201};
    send_image(1'b0, 1'b0);
    @(negedge clk);
    check_eq("cs_good_done", done, 1);
    pulse_reload();
    send_image(1'b0, 1'b1);
    @(negedge clk);
    check_eq("cs_bad_error", error, 1);
    check_eq("cs_bad_done", done, 0);
    @(negedge clk);
    check_eq("cs_bad_cpu", cpu_rst, 0);
    pulse_reload();
    send_image(1'b0, 1'b0);
    settle();
    check_eq("cs_retry_done", done, 1);
    check_eq("cs_retry_cpu", cpu_rst, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
